// File: rtl/nd_nto1.sv
// nd_nto1: NCH-input round-robin message merge into a single four-phase output via an FSZ-deep FIFO.
// Optional FIFO level/full observation ports are enabled by defining NS_ND_NTO1_LEVEL_EN.
`ifndef NS_MESSAGE_FIFO_SIZE
`define NS_MESSAGE_FIFO_SIZE 4
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module nd_nto1 #(
  parameter int NCH = 4,
  parameter int FSZ = `NS_MESSAGE_FIFO_SIZE,
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE,
  parameter int RSZ = `NS_REDUN_SIZE
) (
  input  logic                 i_clk,
  input  logic                 reset,
  output logic                 ready,
  input  logic [NCH-1:0]       rcv_req,
  output logic [NCH-1:0]       rcv_ack,
  input  logic [NCH*ASZ-1:0]   rcv_src,
  input  logic [NCH*ASZ-1:0]   rcv_dst,
  input  logic [NCH*DSZ-1:0]   rcv_dat,
  input  logic [NCH*RSZ-1:0]   rcv_red,
  output logic                 snd0_req,
  input  logic                 snd0_ack,
  output logic [ASZ-1:0]       snd0_src,
  output logic [ASZ-1:0]       snd0_dst,
  output logic [DSZ-1:0]       snd0_dat,
  output logic [RSZ-1:0]       snd0_red
`ifdef NS_ND_NTO1_LEVEL_EN
  ,
  output logic [$clog2(FSZ+1)-1:0] fill_lvl,
  output logic                     full_seen
`endif
);

  localparam int CW = $clog2(FSZ + 1);
  localparam int IW = $clog2(FSZ);
  localparam int PW = $clog2(NCH);
  localparam logic [CW-1:0] CNT_FULL = CW'(FSZ);
  localparam logic [IW-1:0] IDX_LAST = IW'(FSZ - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NCH - 1);
  localparam logic [PW:0]   NCH_W    = (PW + 1)'(NCH);

  logic [CW-1:0]  count;
  logic [IW-1:0]  head;
  logic [IW-1:0]  tail;
  logic [PW-1:0]  ptr;
  logic           busy;

  logic [NCH-1:0] pending;
  logic           found;
  logic [PW-1:0]  win;
  logic [PW:0]    cand;
  logic           accept;
  logic           pop;

  logic [ASZ-1:0] mem_src [FSZ];
  logic [ASZ-1:0] mem_dst [FSZ];
  logic [DSZ-1:0] mem_dat [FSZ];
  logic [RSZ-1:0] mem_red [FSZ];

  // Rotating scan: first pending channel at or after ptr, modulo NCH.
  always_comb begin
    pending = rcv_req & ~rcv_ack;
    found   = 1'b0;
    win     = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      cand = {1'b0, ptr} + (PW + 1)'(k);
      if (cand >= NCH_W) cand = cand - NCH_W;
      if (!found && pending[cand[PW-1:0]]) begin
        found = 1'b1;
        win   = cand[PW-1:0];
      end
    end
  end

  assign accept = ready & found & (count < CNT_FULL);
  assign pop    = ready & ~snd0_req & ~busy & (count != '0);

  always_ff @(posedge i_clk) begin
    if (!reset && accept) begin
      mem_src[head] <= rcv_src[win*ASZ +: ASZ];
      mem_dst[head] <= rcv_dst[win*ASZ +: ASZ];
      mem_dat[head] <= rcv_dat[win*DSZ +: DSZ];
      mem_red[head] <= rcv_red[win*RSZ +: RSZ];
    end
  end

  // Reset and the single init cycle share the clearing branch; ready only rises from init.
  always_ff @(posedge i_clk) begin
    if (reset || !ready) begin
      ready     <= ~reset;
      rcv_ack   <= '0;
      snd0_req  <= 1'b0;
      snd0_src  <= '0;
      snd0_dst  <= '0;
      snd0_dat  <= '0;
      snd0_red  <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ptr       <= '0;
      busy      <= 1'b0;
`ifdef NS_ND_NTO1_LEVEL_EN
      full_seen <= 1'b0;
`endif
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!rcv_req[i] && rcv_ack[i]) rcv_ack[i] <= 1'b0;
      end

      if (accept) begin
        rcv_ack[win] <= 1'b1;
        head         <= (head == IDX_LAST) ? '0 : head + IW'(1);
        ptr          <= (win == PTR_LAST) ? '0 : win + PW'(1);
      end

      if (pop) begin
        snd0_src <= mem_src[tail];
        snd0_dst <= mem_dst[tail];
        snd0_dat <= mem_dat[tail];
        snd0_red <= mem_red[tail];
        snd0_req <= 1'b1;
        busy     <= 1'b1;
        tail     <= (tail == IDX_LAST) ? '0 : tail + IW'(1);
      end else if (snd0_req && snd0_ack) begin
        snd0_req <= 1'b0;
      end else if (busy && !snd0_req && !snd0_ack) begin
        busy <= 1'b0;
      end

      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

`ifdef NS_ND_NTO1_LEVEL_EN
      if ((|pending) && (count == CNT_FULL)) full_seen <= 1'b1;
`endif
    end
  end

`ifdef NS_ND_NTO1_LEVEL_EN
  assign fill_lvl = count;
`endif

endmodule

// File: tb/tb_nd_nto1.sv
// Self-checking bench for nd_nto1: directed/table tests on an FSZ=4 instance and a
// randomized scoreboard run on an FSZ=3 instance.
module tb_nd_nto1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // FSZ=4 instance
  logic        reset = 1'b1;
  logic        ready;
  logic [3:0]  req = '0;
  logic [3:0]  ack;
  logic [31:0] src = '0, dst = '0, dat = '0;
  logic [15:0] red = '0;
  logic        sreq;
  logic        sack = 1'b0;
  logic [7:0]  s_src, s_dst, s_dat;
  logic [3:0]  s_red;
`ifdef NS_ND_NTO1_LEVEL_EN
  logic [2:0]  fill_lvl;
  logic        full_seen;
`endif

  // FSZ=3 instance
  logic        b_reset = 1'b1;
  logic        b_ready;
  logic [3:0]  b_req = '0;
  logic [3:0]  b_ack;
  logic [31:0] b_src = '0, b_dst = '0, b_dat = '0;
  logic [15:0] b_red = '0;
  logic        b_sreq;
  logic        b_sack = 1'b0;
  logic [7:0]  b_s_src, b_s_dst, b_s_dat;
  logic [3:0]  b_s_red;
`ifdef NS_ND_NTO1_LEVEL_EN
  logic [1:0]  b_fill;
  logic        b_full;
`endif

  nd_nto1 #(.NCH(4), .FSZ(4), .ASZ(8), .DSZ(8), .RSZ(4)) dut (
    .i_clk(clk), .reset(reset), .ready(ready),
    .rcv_req(req), .rcv_ack(ack), .rcv_src(src), .rcv_dst(dst), .rcv_dat(dat), .rcv_red(red),
    .snd0_req(sreq), .snd0_ack(sack), .snd0_src(s_src), .snd0_dst(s_dst), .snd0_dat(s_dat),
    .snd0_red(s_red)
`ifdef NS_ND_NTO1_LEVEL_EN
    , .fill_lvl(fill_lvl), .full_seen(full_seen)
`endif
  );

  nd_nto1 #(.NCH(4), .FSZ(3), .ASZ(8), .DSZ(8), .RSZ(4)) dut3 (
    .i_clk(clk), .reset(b_reset), .ready(b_ready),
    .rcv_req(b_req), .rcv_ack(b_ack), .rcv_src(b_src), .rcv_dst(b_dst), .rcv_dat(b_dat),
    .rcv_red(b_red),
    .snd0_req(b_sreq), .snd0_ack(b_sack), .snd0_src(b_s_src), .snd0_dst(b_s_dst),
    .snd0_dat(b_s_dat), .snd0_red(b_s_red)
`ifdef NS_ND_NTO1_LEVEL_EN
    , .fill_lvl(b_fill), .full_seen(b_full)
`endif
  );

  typedef struct packed {
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] dat;
    logic [3:0] red;
  } msg_t;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] exp_ack;
    logic [7:0] exp_dat;
  } vec_t;

  int errors = 0;
  int checks = 0;

  int         quota [4];
  int         seqn = 0;
  int         acc_ch [$];
  logic [7:0] acc_dat [$];
  logic [7:0] out_dat [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_msg(input int c, input logic [7:0] d);
    src[c*8 +: 8] = 8'(c);
    dst[c*8 +: 8] = ~8'(c);
    dat[c*8 +: 8] = d;
    red[c*4 +: 4] = d[3:0];
  endtask

  // Channel sources re-request while quota remains; optional sink completes output handshakes.
  task automatic run_cycles(input int n, input bit sink_en);
    logic [3:0] pa;
    logic       ps;
    logic [7:0] d;
    for (int t = 0; t < n; t++) begin
      pa = ack;
      ps = sreq;
      tick();
      for (int i = 0; i < 4; i++)
        if (ack[i] && !pa[i]) begin
          acc_ch.push_back(i);
          acc_dat.push_back(dat[i*8 +: 8]);
        end
      if (sreq && !ps) out_dat.push_back(s_dat);
      for (int i = 0; i < 4; i++) begin
        if (req[i] && ack[i]) req[i] = 1'b0;
        else if (!req[i] && !ack[i] && quota[i] > 0) begin
          quota[i]--;
          d = {i[1:0], seqn[5:0]};
          seqn++;
          set_msg(i, d);
          req[i] = 1'b1;
        end
      end
      if (sink_en) begin
        if (sreq && !sack) sack = 1'b1;
        else if (!sreq && sack) sack = 1'b0;
      end
    end
  endtask

  task automatic clear_logs();
    acc_ch.delete();
    acc_dat.delete();
    out_dat.delete();
    for (int i = 0; i < 4; i++) quota[i] = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [9];
    msg_t exp_q [$];
    msg_t m, got;
    msg_t b_cur [4];
    logic [3:0] pend, pa, rise, expv;
    logic ps, fnd;
    int w, c, m_ptr, m_occ, b_left, b_dly, delivered;

    // Arbitration table; pointer starts at 3 after the init and single-message tests.
    tbl[0] = '{4'b0101, 4'b0001, 8'h00};
    tbl[1] = '{4'b1000, 4'b1000, 8'h31};
    tbl[2] = '{4'b1110, 4'b0010, 8'h12};
    tbl[3] = '{4'b0011, 4'b0001, 8'h03};
    tbl[4] = '{4'b1111, 4'b0010, 8'h14};
    tbl[5] = '{4'b0100, 4'b0100, 8'h25};
    tbl[6] = '{4'b0111, 4'b0001, 8'h06};
    tbl[7] = '{4'b0000, 4'b0000, 8'h00};
    tbl[8] = '{4'b1001, 4'b1000, 8'h38};

    clear_logs();

    // Reset and init
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_ready", ready, 0);
      check("reset_ack", ack, 0);
      check("reset_sreq", sreq, 0);
      check("reset_sdat", s_dat, 0);
    end
    reset = 1'b0;
    set_msg(1, 8'h5C);
    req[1] = 1'b1;
    #1;
    check("init_ready_before", ready, 0);
    tick();
    check("init_ready_after", ready, 1);
    check("init_no_accept", ack, 0);
    tick();
    check("post_init_accept", ack, 4'b0010);
    run_cycles(12, 1'b1);
    check("init_msg_count", out_dat.size(), 1);
    if (out_dat.size() == 1) check("init_msg_dat", out_dat[0], 8'h5C);

    // Single message
    clear_logs();
    sack = 1'b0;
    set_msg(2, 8'hA5);
    req[2] = 1'b1;
    tick();
    check("single_ack", ack, 4'b0100);
    check("single_no_bypass", sreq, 0);
    tick();
    check("single_sreq", sreq, 1);
    check("single_sdat", s_dat, 8'hA5);
    check("single_ssrc", s_src, 8'h02);
    req[2] = 1'b0;
    tick();
    check("single_ack_drop", ack, 0);
    check("single_hold", {sreq, s_dat}, {1'b1, 8'hA5});
    sack = 1'b1;
    tick();
    check("single_sreq_drop", sreq, 0);
    check("single_dat_stable", s_dat, 8'hA5);
    sack = 1'b0;
    tick();
    tick();

    // Arbitration table; losing requests are withdrawn after the sampled cycle
    for (int v = 0; v < 9; v++) begin
      clear_logs();
      for (int k = 0; k < 4; k++) set_msg(k, 8'(k*16 + v));
      req = tbl[v].mask;
      tick();
      check($sformatf("tbl%0d_ack", v), ack, tbl[v].exp_ack);
      req = '0;
      run_cycles(10, 1'b1);
      check($sformatf("tbl%0d_outs", v), out_dat.size(), (tbl[v].exp_ack != 0) ? 1 : 0);
      if (tbl[v].exp_ack != 0 && out_dat.size() == 1)
        check($sformatf("tbl%0d_dat", v), out_dat[0], tbl[v].exp_dat);
    end

    // Round-robin fairness
    clear_logs();
    for (int i = 0; i < 4; i++) quota[i] = 3;
    run_cycles(300, 1'b1);
    check("rr_accepts", acc_ch.size(), 12);
    check("rr_outputs", out_dat.size(), 12);
    for (int k = 0; k < 12 && k < acc_ch.size(); k++)
      check($sformatf("rr_order%0d", k), acc_ch[k], k % 4);
    for (int k = 0; k < out_dat.size() && k < acc_dat.size(); k++)
      check($sformatf("rr_out%0d", k), out_dat[k], acc_dat[k]);

    // Full FIFO with output stalled
    clear_logs();
    sack = 1'b0;
    quota[0] = 2; quota[1] = 2; quota[2] = 1; quota[3] = 1;
    run_cycles(30, 1'b0);
    check("full_accepts", acc_ch.size(), 5);
    check("full_sreq", sreq, 1);
    check("full_pending", (req & ~ack) != 0, 1);
`ifdef NS_ND_NTO1_LEVEL_EN
    check("full_fill_lvl", fill_lvl, 4);
    check("full_seen_set", full_seen, 1);
`endif
    run_cycles(120, 1'b1);
    check("full_accepts_after", acc_ch.size(), 6);
    check("full_outputs_after", out_dat.size(), 6);
    for (int k = 0; k < out_dat.size() && k < acc_dat.size(); k++)
      check($sformatf("full_out%0d", k), out_dat[k], acc_dat[k]);

    // Put pointer at 0 via a lone channel-3 message
    clear_logs();
    set_msg(3, 8'h3E);
    req[3] = 1'b1;
    run_cycles(14, 1'b1);
    check("ptr_prep_out", out_dat.size(), 1);

    // Mid-operation reset: accepts 0,1,2 leave ptr=3, one loaded, two buffered
    clear_logs();
    sack = 1'b0;
    quota[0] = 1; quota[1] = 1; quota[2] = 1;
    run_cycles(15, 1'b0);
    check("mid_accepts", acc_ch.size(), 3);
    check("mid_sreq", sreq, 1);
`ifdef NS_ND_NTO1_LEVEL_EN
    check("mid_fill_lvl", fill_lvl, 2);
    check("mid_full_seen_sticky", full_seen, 1);
`endif
    reset = 1'b1;
    req = '0;
    tick();
    check("mid_rst_sreq", sreq, 0);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_ready", ready, 0);
    check("mid_rst_fields", {s_src, s_dst, s_dat, s_red}, 0);
`ifdef NS_ND_NTO1_LEVEL_EN
    check("mid_rst_fill_lvl", fill_lvl, 0);
    check("mid_rst_full_seen", full_seen, 0);
`endif
    reset = 1'b0;
    tick();
    check("mid_reinit_ready", ready, 1);
    clear_logs();
    set_msg(1, 8'h71);
    set_msg(3, 8'h73);
    req = 4'b1010;
    tick();
    check("mid_ptr_reset", ack, 4'b0010);
    run_cycles(30, 1'b1);
    check("mid_no_stale", out_dat.size(), 2);
    if (out_dat.size() == 2) begin
      check("mid_out0", out_dat[0], 8'h71);
      check("mid_out1", out_dat[1], 8'h73);
    end

    // Randomized stream on the FSZ=3 instance against a round-robin / FIFO model
    tick();
    b_reset = 1'b0;
    tick();
    check("b_ready", b_ready, 1);
    m_ptr = 0; m_occ = 0; b_left = 20; b_dly = 0; delivered = 0;
    for (int cyc = 0; cyc < 3000 && delivered < 20; cyc++) begin
      pend = b_req & ~b_ack;
      fnd = 1'b0;
      w = 0;
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (!fnd && pend[c]) begin fnd = 1'b1; w = c; end
      end
      if (m_occ >= 3) fnd = 1'b0;
      expv = fnd ? 4'(1 << w) : 4'b0000;
      pa = b_ack;
      ps = b_sreq;
      tick();
      rise = b_ack & ~pa;
      check("rand_accept", rise, expv);
      for (int k = 0; k < 4; k++)
        if (rise[k]) begin
          exp_q.push_back(b_cur[k]);
          m_occ++;
        end
      if (fnd) m_ptr = (w + 1) % 4;
      if (b_sreq && !ps) begin
        got = '{b_s_src, b_s_dst, b_s_dat, b_s_red};
        delivered++;
        m_occ--;
        if (exp_q.size() == 0) check("rand_spurious", got, 0);
        else check("rand_order", got, exp_q.pop_front());
      end
      for (int k = 0; k < 4; k++) begin
        if (b_req[k] && b_ack[k]) b_req[k] = 1'b0;
        else if (!b_req[k] && !b_ack[k] && b_left > 0 && $urandom_range(1, 0) == 1) begin
          b_left--;
          m.src = 8'($urandom);
          m.dst = 8'($urandom);
          m.dat = 8'($urandom);
          m.red = 4'($urandom);
          b_cur[k] = m;
          b_src[k*8 +: 8] = m.src;
          b_dst[k*8 +: 8] = m.dst;
          b_dat[k*8 +: 8] = m.dat;
          b_red[k*4 +: 4] = m.red;
          b_req[k] = 1'b1;
        end
      end
      if (b_sreq && !b_sack) begin
        if (b_dly == 0) begin
          b_sack = 1'b1;
          b_dly = int'($urandom_range(3, 0));
        end else b_dly--;
      end else if (!b_sreq && b_sack) b_sack = 1'b0;
    end
    check("rand_delivered", delivered, 20);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
